cache_line_mem: RTL and testbench



---
 rtl/cache_def_pkg.sv | 34 +++
 rtl/cache_line_array.sv | 28 ++
 rtl/cache_line_mem.sv | 147 ++++++++++++++
 tb/tb_cache_line_mem.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_def_pkg.sv
// Shared cache definitions: line data type, memory request/response shapes,
// the main-memory model FSM states and a saturating counter helper.
package cache_def;

  localparam int LINE_BYTES       = 64;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int LINE_BITS        = LINE_BYTES * 8;

  typedef logic [LINE_BITS-1:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } mem_state_e;

  // Request counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Single-port line storage with registered read. No reset: contents start at
// zero and survive resets of the surrounding logic.
module cache_line_array
  import cache_def::*;
#(
  parameter int LINES = 1024,
  localparam int AW   = $clog2(LINES)
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [AW-1:0]  addr_i,
  input  cache_data_type wdata_i,
  output cache_data_type rdata_o
);

  cache_data_type lines_q [LINES] = '{default: '0};
  cache_data_type rdata_q = '0;

  always_ff @(posedge clk) begin
    if (we_i) begin
      lines_q[addr_i] <= wdata_i;
    end
    rdata_q <= lines_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_line_mem.sv
// Line-granular main-memory model behind the cache controller: one 512-bit
// line read or write-back per request, answered after a fixed latency.
module cache_line_mem
  import cache_def::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int LATENCY   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [31:0]    mem_req_addr,
  input  cache_data_type mem_req_data,
  input  logic           mem_req_rw,
  input  logic           mem_req_valid,
  output cache_data_type mem_rdata,
  output logic           mem_ready,
  output logic           busy,
  output logic [31:0]    rd_count,
  output logic [31:0]    wr_count
);

  localparam int         IDX_W = $clog2(MEM_LINES);
  localparam logic [7:0] LOAD  = 8'(LATENCY - 1);

  mem_state_e     state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  cache_data_type data_q, data_d;
  logic           rw_q, rw_d;
  cache_data_type rdata_q, rdata_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic [31:0]    rd_count_q, rd_count_d;
  logic [31:0]    wr_count_q, wr_count_d;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] arr_idx;
  logic             arr_we;
  cache_data_type   arr_rdata;
  logic             accept;
  logic             complete;
  logic             unused_addr_bits;

  assign req_idx  = mem_req_addr[LINE_OFFSET_BITS +: IDX_W];
  assign unused_addr_bits = ^{mem_req_addr[31:LINE_OFFSET_BITS+IDX_W],
                              mem_req_addr[LINE_OFFSET_BITS-1:0]};

  assign accept   = (state_q == IDLE) && mem_req_valid;
  assign complete = (state_q == BUSY) && (cnt_q == 8'd0);

  // While idle the array is addressed by the incoming request, so its
  // registered read data is already valid on the first BUSY edge.
  assign arr_idx  = (state_q == IDLE) ? req_idx : idx_q;
  assign arr_we   = complete && rw_q;

  cache_line_array #(
    .LINES(MEM_LINES)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .addr_i (arr_idx),
    .wdata_i(data_q),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_req_valid) state_d = BUSY;
      BUSY:    if (cnt_q == 8'd0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    rw_d       = rw_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;

    if (accept) begin
      idx_d  = req_idx;
      data_d = mem_req_data;
      rw_d   = mem_req_rw;
      cnt_d  = LOAD;
      busy_d = 1'b1;
    end else if (complete) begin
      if (rw_q) begin
        wr_count_d = sat_inc(wr_count_q);
      end else begin
        rdata_d    = arr_rdata;
        rd_count_d = sat_inc(rd_count_q);
      end
      ready_d = 1'b1;
      busy_d  = 1'b0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // An asynchronous reset drops any request in flight, including a pending
  // ready pulse; the array itself is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_cache_line_mem.sv
// Self-checking bench for cache_line_mem: a LATENCY=8 instance for the main
// vectors and corner sequences, and a LATENCY=1 instance for the short path.
module tb_cache_line_mem;
  import cache_def::*;

  localparam cache_data_type DataBeef = {16{32'hDEAD_BEEF}};
  localparam cache_data_type DataA    = {8{64'hA5A5_0000_1111_2222}};
  localparam cache_data_type DataC    = {16{32'hC0DE_0080}};
  localparam cache_data_type DataD    = {16{32'h0D0D_0100}};
  localparam cache_data_type DataE    = {16{32'hEEEE_5555}};
  localparam cache_data_type DataF    = {16{32'hF00D_0C40}};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] reqAddr = '0;
  cache_data_type reqData = '0;
  logic reqRw = 1'b0;
  logic valid0 = 1'b0;
  logic valid1 = 1'b0;

  cache_data_type rdata0, rdata1;
  logic ready0, ready1, busy0, busy1;
  logic [31:0] rdCount0, wrCount0, rdCount1, wrCount1;

  typedef struct {
    cache_data_type rdata;
    logic [31:0] rdCnt;
    logic [31:0] wrCnt;
  } expect_t;

  typedef struct {
    logic rw;
    logic [31:0] addr;
    cache_data_type data;
    cache_data_type expRdata;
  } vec_t;

  expect_t scoreboard[$];
  vec_t vecs[8];
  logic [31:0] modelRd[2];
  logic [31:0] modelWr[2];
  int latency[2];
  int total = 0;
  int bad = 0;

  cache_line_mem #(.MEM_LINES(1024), .LATENCY(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_addr(reqAddr), .mem_req_data(reqData),
    .mem_req_rw(reqRw), .mem_req_valid(valid0),
    .mem_rdata(rdata0), .mem_ready(ready0), .busy(busy0),
    .rd_count(rdCount0), .wr_count(wrCount0)
  );

  cache_line_mem #(.MEM_LINES(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .mem_req_addr(reqAddr), .mem_req_data(reqData),
    .mem_req_rw(reqRw), .mem_req_valid(valid1),
    .mem_rdata(rdata1), .mem_ready(ready1), .busy(busy1),
    .rd_count(rdCount1), .wr_count(wrCount1)
  );

  always #5 clk = ~clk;

  function automatic logic getReady(input int sel);
    return (sel == 1) ? ready1 : ready0;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 1) ? busy1 : busy0;
  endfunction

  function automatic cache_data_type getRdata(input int sel);
    return (sel == 1) ? rdata1 : rdata0;
  endfunction

  function automatic logic [31:0] getRdCount(input int sel);
    return (sel == 1) ? rdCount1 : rdCount0;
  endfunction

  function automatic logic [31:0] getWrCount(input int sel);
    return (sel == 1) ? wrCount1 : wrCount0;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic driveRequest(input int sel, input logic rw, input logic [31:0] addr, input cache_data_type data);
    reqRw   = rw;
    reqAddr = addr;
    reqData = data;
    if (sel == 1) valid1 = 1'b1;
    else          valid0 = 1'b1;
  endtask

  task automatic pushExpect(input int sel, input logic rw, input cache_data_type expRdata);
    expect_t e;
    if (rw) begin
      if (modelWr[sel] != 32'hFFFF_FFFF) modelWr[sel] = modelWr[sel] + 32'd1;
    end else begin
      if (modelRd[sel] != 32'hFFFF_FFFF) modelRd[sel] = modelRd[sel] + 32'd1;
    end
    e.rdata = expRdata;
    e.rdCnt = modelRd[sel];
    e.wrCnt = modelWr[sel];
    scoreboard.push_back(e);
  endtask

  // Called just after the acceptance edge; returns on the sample where ready is seen.
  task automatic waitReady(input int sel, input string name);
    int k;
    bit seen;
    expect_t e;
    k = 0;
    seen = 1'b0;
    while (!seen && k < latency[sel] + 6) begin
      @(negedge clk);
      k++;
      if (getReady(sel)) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got no mem_ready in %0d cycles, want one at %0d", name, k, latency[sel] + 1);
      if (scoreboard.size() > 0) void'(scoreboard.pop_front());
    end else begin
      checkOutput({name, "_lat"}, 512'(k), 512'(latency[sel] + 1));
      checkOutput({name, "_busy_done"}, 512'(getBusy(sel)), 512'd0);
      if (scoreboard.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s_extra: got an unexpected mem_ready, want none", name);
      end else begin
        e = scoreboard.pop_front();
        checkOutput({name, "_rdata"}, getRdata(sel), e.rdata);
        checkOutput({name, "_rdcnt"}, 512'(getRdCount(sel)), 512'(e.rdCnt));
        checkOutput({name, "_wrcnt"}, 512'(getWrCount(sel)), 512'(e.wrCnt));
      end
    end
  endtask

  task automatic applyStimulus(input int sel, input logic rw, input logic [31:0] addr,
                               input cache_data_type data, input cache_data_type expRdata,
                               input string name);
    @(negedge clk);
    driveRequest(sel, rw, addr, data);
    pushExpect(sel, rw, expRdata);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    checkOutput({name, "_busy"}, 512'(getBusy(sel)), 512'd1);
    waitReady(sel, name);
    @(negedge clk);
    checkOutput({name, "_pulse"}, 512'(getReady(sel)), 512'd0);
  endtask

  initial begin
    bit sawReady;
    latency[0] = 8;
    latency[1] = 1;
    modelRd[0] = '0; modelWr[0] = '0;
    modelRd[1] = '0; modelWr[1] = '0;

    vecs[0] = '{1'b0, 32'h0000_0040, '0,       '0};
    vecs[1] = '{1'b1, 32'h0000_1F80, DataBeef, '0};
    vecs[2] = '{1'b0, 32'h0000_1FBC, '0,       DataBeef};
    vecs[3] = '{1'b1, 32'h0001_0000, DataA,    DataBeef};
    vecs[4] = '{1'b0, 32'h0000_0000, '0,       DataA};
    vecs[5] = '{1'b1, 32'h0000_0080, DataC,    DataA};
    vecs[6] = '{1'b0, 32'h0003_FFC0, '0,       '0};
    vecs[7] = '{1'b0, 32'h0000_1F80, '0,       DataBeef};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 512'(ready0), 512'd0);
    checkOutput("reset_rdata", rdata0, '0);
    checkOutput("reset_busy", 512'(busy0), 512'd0);
    checkOutput("reset_rdcnt", 512'(rdCount0), 512'd0);
    checkOutput("reset_wrcnt", 512'(wrCount0), 512'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].expRdata, $sformatf("vec%0d", i));
    end

    // Write-back then allocate, with valid held and the request switched on ready.
    @(negedge clk);
    driveRequest(0, 1'b1, 32'h0000_0100, DataD);
    pushExpect(0, 1'b1, DataBeef);
    @(posedge clk);
    #1;
    waitReady(0, "b2b_wr");
    driveRequest(0, 1'b0, 32'h0000_0100, '0);
    pushExpect(0, 1'b0, DataD);
    @(posedge clk);
    #1;
    checkOutput("b2b_gap_busy", 512'(busy0), 512'd0);
    checkOutput("b2b_gap_ready", 512'(ready0), 512'd0);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    checkOutput("b2b_accept", 512'(busy0), 512'd1);
    waitReady(0, "b2b_rd");
    @(negedge clk);
    checkOutput("b2b_pulse", 512'(ready0), 512'd0);

    // Reset three cycles into a write must abort it completely.
    @(negedge clk);
    driveRequest(0, 1'b1, 32'h0000_0080, DataE);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 512'(busy0), 512'd0);
    checkOutput("abort_wrcnt", 512'(wrCount0), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelRd[0] = '0; modelWr[0] = '0;
    modelRd[1] = '0; modelWr[1] = '0;
    sawReady = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ready0) sawReady = 1'b1;
    end
    checkOutput("abort_no_ready", 512'(sawReady), 512'd0);
    applyStimulus(0, 1'b0, 32'h0000_0080, '0, DataC, "abort_rd");

    // Short-latency instance.
    applyStimulus(1, 1'b1, 32'h0000_0C40, DataF, '0, "l1_wr");
    applyStimulus(1, 1'b0, 32'h0000_0C40, '0, DataF, "l1_rd");

    @(negedge clk);
    force dut1.rd_count_q = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    release dut1.rd_count_q;
    modelRd[1] = 32'hFFFF_FFFF;
    applyStimulus(1, 1'b0, 32'h0000_0C40, '0, DataF, "sat_rd");

    // Reset while the ready pulse is showing clears it at once.
    @(negedge clk);
    driveRequest(1, 1'b0, 32'h0000_0C40, '0);
    pushExpect(1, 1'b0, DataF);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    waitReady(1, "ack_rd");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ack_reset_ready", 512'(ready1), 512'd0);
    checkOutput("ack_reset_rdata", rdata1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
